// File: rtl/mod3_seq_checker.sv
// Lock-and-check monitor for a 2-bit mod-3 counter stream (00 -> 01 -> 10 -> 00).
// Optional build macro MOD3_CHK_HOLD_EN: a repeated legal code is a hold, not an error.
module mod3_seq_checker #(
  parameter int unsigned LOCK_CNT = 3,
  parameter int unsigned ERR_W    = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic [1:0]       code,
  output logic             locked,
  output logic             err,
  output logic             ill,
  output logic             wrap,
  output logic [1:0]       phase,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {StHunt, StAcq, StLocked} state_e;

  state_e     state_q;
  logic [1:0] ref_q;
  logic [3:0] good_q;

  logic             legal;
  logic             is_next;
  logic             is_hold;
  logic [1:0]       succ;
  logic [4:0]       good_inc;
  logic [ERR_W-1:0] cnt_inc;

  always_comb begin
    succ = 2'b00;
    unique case (ref_q)
      2'b00:   succ = 2'b01;
      2'b01:   succ = 2'b10;
      default: succ = 2'b00;
    endcase
  end

  assign legal   = (code != 2'b11);
  assign is_next = legal && (code == succ);
`ifdef MOD3_CHK_HOLD_EN
  assign is_hold = legal && (code == ref_q);
`else
  assign is_hold = 1'b0;
`endif

  assign good_inc = {1'b0, good_q} + 5'd1;
  assign cnt_inc  = (err_cnt == {ERR_W{1'b1}}) ? err_cnt : err_cnt + ERR_W'(1);
  assign phase    = ref_q;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q <= StHunt;
      ref_q   <= 2'b00;
      good_q  <= 4'd0;
      locked  <= 1'b0;
      err     <= 1'b0;
      ill     <= 1'b0;
      wrap    <= 1'b0;
      err_cnt <= '0;
    end else begin
      // Pulses default low; only a qualified sample can raise them.
      err  <= 1'b0;
      ill  <= 1'b0;
      wrap <= 1'b0;
      if (en) begin
        unique case (state_q)
          StHunt: begin
            if (!legal) begin
              ill <= 1'b1;
            end else begin
              ref_q   <= code;
              good_q  <= 4'd0;
              state_q <= StAcq;
            end
          end
          StAcq: begin
            if (!legal) begin
              ill     <= 1'b1;
              state_q <= StHunt;
            end else if (is_hold) begin
              // hold: nothing changes
            end else if (is_next) begin
              ref_q  <= code;
              good_q <= good_inc[3:0];
              if (good_inc == 5'(LOCK_CNT)) begin
                state_q <= StLocked;
                locked  <= 1'b1;
              end
            end else begin
              ref_q  <= code;
              good_q <= 4'd0;
            end
          end
          StLocked: begin
            if (!legal) begin
              err     <= 1'b1;
              ill     <= 1'b1;
              err_cnt <= cnt_inc;
              locked  <= 1'b0;
              state_q <= StHunt;
            end else if (is_hold) begin
              // hold: nothing changes
            end else if (is_next) begin
              ref_q <= code;
              wrap  <= (ref_q == 2'b10) && (code == 2'b00);
            end else begin
              err     <= 1'b1;
              err_cnt <= cnt_inc;
              ref_q   <= code;
              good_q  <= 4'd0;
              locked  <= 1'b0;
              state_q <= StAcq;
            end
          end
          default: state_q <= StHunt;
        endcase
      end
    end
  end

endmodule

// File: doc/mod3_seq_checker.md
# mod3_seq_checker

Receive-side companion to the 2-bit mod-3 flip-flop counter. It samples the counter's 2-bit output and checks it against the legal cycle 00 → 01 → 10 → 00. It acquires lock after a run of correct transitions, then flags and counts sequence errors. It also reports illegal codes, the current phase and wrap events, for use as an on-chip monitor downstream of the counter.

## Interface
- LOCK_CNT, 3: consecutive correct transitions required to enter LOCKED; legal range 1..15.
- ERR_W, 4: width of the saturating error counter.
- clk  input  1  rising-edge clock, shared with the counter.
- res  input  1  reset, asynchronous and active-high; clears all state and outputs.
- en  input  1  sample qualifier; `code` is evaluated only on cycles where `en`=1.
- code  input  2  counter output under check.
- locked  output  1  high while in LOCKED.
- err  output  1  one-cycle pulse on a bad transition while LOCKED.
- ill  output  1  one-cycle pulse whenever a sampled `code` is 11, in any state.
- wrap  output  1  one-cycle pulse on a good 10→00 transition while LOCKED.
- phase  output  2  last sampled legal code; holds while `en`=0.
- err_cnt  output  ERR_W  saturating count of `err` pulses.

## Operation
- Successor function: next(00)=01, next(01)=10, next(10)=00. Code 11 is illegal.
- Internal registers:
  - `ref`: last accepted code.
  - `good`: correct-transition counter, 4 bits.
  - `state`: one of HUNT, ACQ, LOCKED.
- A sample is "good" when code == next(ref) and "bad" otherwise. Code 11 is always bad.
- HUNT:
  - Legal sample: ref ← code, good ← 0, go to ACQ.
  - Code 11: ill=1, stay in HUNT.
- ACQ:
  - Good sample: ref ← code, good ← good+1; when good+1 == LOCK_CNT, go to LOCKED.
  - Bad legal sample: ref ← code, good ← 0, stay in ACQ. No `err`.
  - Code 11: ill=1, go to HUNT.
- LOCKED:
  - Good sample: ref ← code; wrap=1 if ref==10 and code==00.
  - Bad legal sample: err=1, err_cnt += 1 (saturating at all ones), ref ← code, good ← 0, go to ACQ.
  - Code 11: err=1, ill=1, err_cnt += 1, go to HUNT.
- `en`=0: no state change, and all pulses are 0.
- `phase` follows `ref`.
- `err_cnt` never wraps and is cleared only by `res`.

## Timing
- All outputs are registered. The effect of a sample taken at edge N is visible after edge N, i.e. one-cycle latency.
- `locked` rises in the same cycle as the register update for the LOCK_CNT-th good transition.
- `locked` falls in the same cycle that `err` pulses.
- Reset values: state=HUNT, ref=00, good=0, locked=0, err=0, ill=0, wrap=0, phase=00, err_cnt=0.
- `res` asserted mid-operation clears everything immediately, without waiting for a clock edge. The first edge after `res` is released is treated as a HUNT sample.
- Simultaneous err and ill (code 11 while LOCKED): both pulse in the same cycle, and err_cnt increments once.
- Back-to-back `en` cycles are fully supported. One sample is processed per `en` cycle, with no bubbles.

## Configuration
- MOD3_CHK_HOLD_EN defined:
  - A sample with code == ref (legal code) is a hold.
  - A hold causes no state change, no `good` increment, no `err` and no `wrap`.
  - This supports counters with a clock enable.
- MOD3_CHK_HOLD_EN undefined: a repeated code is a bad transition. It resets acquisition in ACQ and raises `err` in LOCKED.

## Test plan
- Reset mid-stream: assert `res` between edges while locked → locked, err_cnt and phase read 0 without any clock edge; a subsequent clean stream re-locks after 1+LOCK_CNT samples.
- Clean lock: `res` pulse, then `en`=1 with the stream 00,01,10,00,01,10 → locked rises after the 4th sample (LOCK_CNT=3); wrap pulses on the 10→00 transition at the 7th sample if the stream continues.
- Skip error: after lock, the stream goes 01 then 00 → err=1 for one cycle, err_cnt=1, locked=0, state ACQ; lock returns after 3 further good transitions.
- Illegal code: after lock, drive 11 → err=1 and ill=1 in the same cycle, err_cnt=1, locked=0; the next legal code is accepted as the HUNT sample.
- Saturation: ERR_W=4, force 20 lock/error cycles → err_cnt stops at 15.
- Hold, both builds: after lock, drive 01,01,10 → with MOD3_CHK_HOLD_EN, locked stays 1 and err=0; without it, err pulses once at the repeated 01.
